// File: rtl/lane_controller.sv
// Player lane controller: debounces left/right buttons into lane-change requests
// and steps a signed horizontal offset toward the selected lane once per frame.
module lane_controller #(
    parameter int WIDTH    = 12,
    parameter int LANE_DX  = 100,
    parameter int STEP     = 20,
    parameter int DEBOUNCE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    btn_l,
    input  logic                    btn_r,
    input  logic                    enable,
    output logic signed [WIDTH-1:0] hoffset,
    output logic [1:0]              lane,
    output logic                    moving
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic signed [WIDTH-1:0] DX_W    = WIDTH'(LANE_DX);
    localparam logic signed [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    typedef enum logic [1:0] {REQ_NONE, REQ_LEFT, REQ_RIGHT} req_t;
    typedef enum logic {IDLE, MOVE} state_t;

    // Index 0 = left button, index 1 = right button
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press_q, press_d;

    req_t                    pend_q, pend_d;
    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic signed [WIDTH-1:0] hoff_q, hoff_d;
    logic signed [WIDTH-1:0] target;
    logic signed [WIDTH-1:0] stepped;
    logic                    consume;

    function automatic logic signed [WIDTH-1:0] lane_pos(input logic [1:0] l);
        case (l)
            2'd0:    return -DX_W;
            2'd2:    return DX_W;
            default: return '0;
        endcase
    endfunction

    // Difference is taken one bit wider so it can never wrap
    function automatic logic signed [WIDTH-1:0] step_toward(
        input logic signed [WIDTH-1:0] pos,
        input logic signed [WIDTH-1:0] tgt
    );
        logic signed [WIDTH:0] diff;
        logic signed [WIDTH:0] lim;
        diff = {tgt[WIDTH-1], tgt} - {pos[WIDTH-1], pos};
        lim  = (WIDTH+1)'(STEP);
        if ((diff <= lim) && (diff >= -lim)) return tgt;
        else if (diff > 0)                   return pos + STEP_W;
        else                                 return pos - STEP_W;
    endfunction

    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_MAX) lvl_d[i] = ~lvl_q[i];
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press_d = lvl_d & ~lvl_q;
    end

    assign target  = lane_pos(lane_q);
    assign stepped = step_toward(hoff_q, target);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hoff_d  = hoff_q;
        consume = 1'b0;
        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    if (pend_q == REQ_LEFT) begin
                        consume = 1'b1;
                        if (lane_q != 2'd0) begin
                            lane_d  = lane_q - 2'd1;
                            state_d = MOVE;
                        end
                    end else if (pend_q == REQ_RIGHT) begin
                        consume = 1'b1;
                        if (lane_q != 2'd2) begin
                            lane_d  = lane_q + 2'd1;
                            state_d = MOVE;
                        end
                    end
                end
                MOVE: begin
                    hoff_d = stepped;
                    if (stepped == target) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A fresh press wins over consumption so a pulse coinciding with a tick is kept
    always_comb begin
        pend_d = pend_q;
        if (!enable)                   pend_d = REQ_NONE;
        else if (press_q == 2'b01)     pend_d = REQ_LEFT;
        else if (press_q == 2'b10)     pend_d = REQ_RIGHT;
        else if (consume)              pend_d = REQ_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            lvl_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            press_q  <= '0;
            pend_q   <= REQ_NONE;
            state_q  <= IDLE;
            lane_q   <= 2'd1;
            hoff_q   <= '0;
        end else begin
            sync1_q  <= {btn_r, btn_l};
            sync2_q  <= sync1_q;
            lvl_q    <= lvl_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            press_q  <= press_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            lane_q   <= lane_d;
            hoff_q   <= hoff_d;
        end
    end

    assign hoffset = hoff_q;
    assign lane    = lane_q;
    assign moving  = (state_q == MOVE);

endmodule

// File: tb/tb_lane_controller.sv
// Bench for lane_controller: directed vector table, reset-mid-move sequence,
// and randomized press/tick/enable traffic against a lane-level reference model.
module tb_lane_controller;

    localparam int W   = 12;
    localparam int DX  = 100;
    localparam int STP = 30;
    localparam int DB  = 16;

    localparam int A_TICK   = 0;
    localparam int A_PL     = 1;
    localparam int A_PR     = 2;
    localparam int A_BOTH   = 3;
    localparam int A_GLITCH = 4;
    localparam int A_EN0    = 5;
    localparam int A_EN1    = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                frame_tick = 1'b0;
    logic                btn_l = 1'b0;
    logic                btn_r = 1'b0;
    logic                enable = 1'b1;
    logic signed [W-1:0] hoffset;
    logic [1:0]          lane;
    logic                moving;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int act;
        int h;
        int l;
        int m;
    } vec_t;
    vec_t tbl[$];

    // Reference model state: position in pixels, lane index, pending 0/1/2
    int m_pos, m_lane, m_mov, m_pend, m_en;

    lane_controller #(.WIDTH(W), .LANE_DX(DX), .STEP(STP), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_l(btn_l), .btn_r(btn_r),
        .enable(enable), .hoffset(hoffset), .lane(lane), .moving(moving)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int eh, input int el, input int em);
        int h;
        h = hoffset;
        tests++;
        if (h != eh || int'(lane) != el || int'(moving) != em) begin
            fails++;
            $display("FAIL %s: got hoffset=%0d lane=%0d moving=%0d, expected hoffset=%0d lane=%0d moving=%0d",
                     name, h, lane, moving, eh, el, em);
        end
    endtask

    task automatic do_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_press(input logic l, input logic r, input int hold);
        @(negedge clk);
        btn_l = l;
        btn_r = r;
        repeat (hold) @(negedge clk);
        btn_l = 1'b0;
        btn_r = 1'b0;
        repeat (DB + 8) @(negedge clk);
    endtask

    task automatic apply(input int act);
        case (act)
            A_TICK:   do_tick();
            A_PL:     do_press(1'b1, 1'b0, DB + 8);
            A_PR:     do_press(1'b0, 1'b1, DB + 8);
            A_BOTH:   do_press(1'b1, 1'b1, DB + 8);
            A_GLITCH: do_press(1'b0, 1'b1, 10);
            A_EN0:    begin @(negedge clk) enable = 1'b0; @(negedge clk); end
            A_EN1:    begin @(negedge clk) enable = 1'b1; @(negedge clk); end
            default:  ;
        endcase
    endtask

    task automatic add(input int act, input int h, input int l, input int m);
        vec_t v;
        v.act = act; v.h = h; v.l = l; v.m = m;
        tbl.push_back(v);
    endtask

    task automatic model_tick();
        int tgt, d;
        if (m_mov != 0) begin
            tgt = (m_lane - 1) * DX;
            d = tgt - m_pos;
            if (d <= STP && d >= -STP) begin
                m_pos = tgt;
                m_mov = 0;
            end else begin
                m_pos += (d > 0) ? STP : -STP;
            end
        end else if (m_pend == 1) begin
            if (m_lane > 0) begin m_lane--; m_mov = 1; end
            m_pend = 0;
        end else if (m_pend == 2) begin
            if (m_lane < 2) begin m_lane++; m_mov = 1; end
            m_pend = 0;
        end
    endtask

    initial begin
        // Directed vectors (STEP=30, LANE_DX=100)
        add(A_GLITCH, 0, 1, 0);
        for (int i = 0; i < 3; i++) add(A_TICK, 0, 1, 0);
        add(A_PR, 0, 1, 0);
        add(A_TICK, 0, 2, 1);   add(A_TICK, 30, 2, 1);  add(A_TICK, 60, 2, 1);
        add(A_TICK, 90, 2, 1);  add(A_TICK, 100, 2, 0); add(A_TICK, 100, 2, 0);
        add(A_PR, 100, 2, 0);   add(A_TICK, 100, 2, 0); add(A_TICK, 100, 2, 0);
        add(A_PL, 100, 2, 0);
        add(A_TICK, 100, 1, 1); add(A_TICK, 70, 1, 1);  add(A_TICK, 40, 1, 1);
        add(A_TICK, 10, 1, 1);  add(A_TICK, 0, 1, 0);
        add(A_PL, 0, 1, 0);
        add(A_TICK, 0, 0, 1);   add(A_TICK, -30, 0, 1); add(A_TICK, -60, 0, 1);
        add(A_TICK, -90, 0, 1); add(A_TICK, -100, 0, 0);
        add(A_PR, -100, 0, 0);  add(A_TICK, -100, 1, 1); add(A_TICK, -70, 1, 1);
        add(A_PL, -70, 1, 1);   add(A_TICK, -40, 1, 1); add(A_TICK, -10, 1, 1);
        add(A_TICK, 0, 1, 0);   add(A_TICK, 0, 0, 1);   add(A_TICK, -30, 0, 1);
        add(A_TICK, -60, 0, 1); add(A_TICK, -90, 0, 1); add(A_TICK, -100, 0, 0);
        add(A_BOTH, -100, 0, 0); add(A_TICK, -100, 0, 0);
        add(A_EN0, -100, 0, 0); add(A_PR, -100, 0, 0);  add(A_EN1, -100, 0, 0);
        add(A_TICK, -100, 0, 0); add(A_TICK, -100, 0, 0);
        add(A_PR, -100, 0, 0);  add(A_TICK, -100, 1, 1); add(A_EN0, -100, 1, 1);
        add(A_TICK, -70, 1, 1); add(A_TICK, -40, 1, 1); add(A_TICK, -10, 1, 1);
        add(A_TICK, 0, 1, 0);   add(A_EN1, 0, 1, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 0, 1, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].act);
            check($sformatf("vec%0d_act%0d", i, tbl[i].act), tbl[i].h, tbl[i].l, tbl[i].m);
        end

        // Reset in the middle of a move with a request pending
        apply(A_PR);
        apply(A_TICK); check("rm_start", 0, 2, 1);
        apply(A_TICK); check("rm_30", 30, 2, 1);
        apply(A_PL);
        apply(A_TICK); check("rm_60", 60, 2, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("rm_reset", 0, 1, 0);
        apply(A_TICK); check("rm_after_tick", 0, 1, 0);

        // Randomized traffic against the reference model
        m_pos = 0; m_lane = 1; m_mov = 0; m_pend = 0; m_en = 1;
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) begin
                apply(A_TICK);
                model_tick();
                check($sformatf("rand%0d_tick", n), m_pos, m_lane, m_mov);
            end else if (r < 7) begin
                apply(A_PL);
                if (m_en != 0) m_pend = 1;
            end else if (r < 9) begin
                apply(A_PR);
                if (m_en != 0) m_pend = 2;
            end else begin
                if (m_en != 0) begin
                    apply(A_EN0);
                    m_en = 0;
                    m_pend = 0;
                end else begin
                    apply(A_EN1);
                    m_en = 1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
